// File: rtl/syn_pkg.sv
// Shared types, sizing helpers and the clamp function for synapse_current_gen.
package syn_pkg;

  localparam int DEF_N_IN      = 4;
  localparam int DEF_W_WIDTH   = 8;
  localparam int DEF_CUR_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } cfg_state_e;

  // Signed width that holds acc plus every weight at once without wrapping.
  function automatic int sum_width(input int cur_w, input int w_w, input int n_in);
    return ((cur_w > w_w) ? cur_w : w_w) + $clog2(n_in + 1) + 1;
  endfunction

  function automatic int cur_max(input int cur_w);
    return (1 << cur_w) - 1;
  endfunction

  function automatic int clamp(input int s, input int hi);
    if (s < 0) return 0;
    if (s > hi) return hi;
    return s;
  endfunction

endpackage

// File: rtl/syn_weight_regfile.sv
// N_IN x W_WIDTH weight registers: one write port, all weights read in parallel.
module syn_weight_regfile #(
  parameter int N_IN    = 4,
  parameter int W_WIDTH = 8,
  parameter int A_W     = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      we,
  input  logic [A_W-1:0]            waddr,
  input  logic [W_WIDTH-1:0]        wdata,
  output logic [N_IN*W_WIDTH-1:0]   weights
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      weights <= '0;
    end else if (we) begin
      for (int i = 0; i < N_IN; i++) begin
        if (32'(waddr) == i) weights[i*W_WIDTH +: W_WIDTH] <= wdata;
      end
    end
  end

endmodule

// File: rtl/synapse_current_gen.sv
// Spike-to-current front end: weighted spike accumulation, periodic exponential decay,
// saturating current output. Define SYN_INHIBIT_EN for signed (inhibitory) weights.
module synapse_current_gen
  import syn_pkg::*;
#(
  parameter int N_IN         = DEF_N_IN,
  parameter int W_WIDTH      = DEF_W_WIDTH,
  parameter int CUR_WIDTH    = DEF_CUR_WIDTH,
  parameter int DECAY_SHIFT  = 2,
  parameter int DECAY_PERIOD = 4,
  localparam int A_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_IN-1:0]      spk_in,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [A_W-1:0]       cfg_addr,
  input  logic [W_WIDTH-1:0]   cfg_weight,
  output logic                 cfg_err,
  output logic [CUR_WIDTH-1:0] current,
  output logic                 current_sat,
  output logic [0:0]           cfg_state
);

  localparam int S_W     = sum_width(CUR_WIDTH, W_WIDTH, N_IN);
  localparam int CNT_W   = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam int CUR_MAX = cur_max(CUR_WIDTH);

  // Handshake: a config write transfers on a rising edge where cfg_valid && cfg_ready;
  // the requester holds cfg_valid, cfg_addr and cfg_weight stable until then.

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (cnt == CNT_W'(DECAY_PERIOD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= tick ? '0 : cnt + 1'b1;
  end

  cfg_state_e          state;
  logic [A_W-1:0]      addr_q;
  logic [W_WIDTH-1:0]  weight_q;
  logic                addr_ok;

  assign cfg_ready = (state == IDLE);
  assign addr_ok   = (32'(addr_q) < N_IN);
  assign cfg_err   = (state == COMMIT) && !addr_ok;
  assign cfg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      weight_q <= '0;
    end else if (state == IDLE) begin
      if (cfg_valid) begin
        addr_q   <= cfg_addr;
        weight_q <= cfg_weight;
        state    <= COMMIT;
      end
    end else begin
      state <= IDLE;
    end
  end

  logic [N_IN*W_WIDTH-1:0] weights;

  // The write lands at the end of the COMMIT cycle, so a spike in that cycle sees the old weight.
  syn_weight_regfile #(
    .N_IN    (N_IN),
    .W_WIDTH (W_WIDTH),
    .A_W     (A_W)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      ((state == COMMIT) && addr_ok),
    .waddr   (addr_q),
    .wdata   (weight_q),
    .weights (weights)
  );

  logic signed [S_W-1:0] dec;
  logic signed [S_W-1:0] sum;
  logic [CUR_WIDTH-1:0]  acc_next;
  logic                  sat_next;
  int                    s_int;
  int                    c_int;

  always_comb begin
    dec = '0;
    if (tick && current != '0) begin
      dec = S_W'(current >> DECAY_SHIFT);
      if (dec == '0) dec = S_W'(1);
    end
    sum = S_W'(current) - dec;
    for (int i = 0; i < N_IN; i++) begin
      if (spk_in[i]) begin
`ifdef SYN_INHIBIT_EN
        sum = sum + S_W'($signed(weights[i*W_WIDTH +: W_WIDTH]));
`else
        sum = sum + S_W'(weights[i*W_WIDTH +: W_WIDTH]);
`endif
      end
    end
    s_int    = int'(sum);
    c_int    = clamp(s_int, CUR_MAX);
    acc_next = CUR_WIDTH'(c_int);
    sat_next = (c_int != s_int);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      current     <= '0;
      current_sat <= 1'b0;
    end else begin
      current     <= acc_next;
      current_sat <= sat_next;
    end
  end

endmodule
